// File: rtl/eng_pipe_pkg.sv
// Shared types for the fa->xa fetch pipeline.
// PC/instruction bundle and fetch FSM states.
package eng_pipe_pkg;

    localparam int FA_PC_W   = 16;
    localparam int FA_INST_W = 32;

    typedef logic [FA_PC_W-1:0]   pc_t;
    typedef logic [FA_INST_W-1:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fa_xa_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fa_state_t;

endpackage

// File: rtl/eng_pipe_fa_q.sv
// Two-entry issue FIFO between ROM return and the xa handshake.
// Head entry lives in its own register so it drives o_xa_* directly.
module eng_pipe_fa_q
    import eng_pipe_pkg::*;
#(
    parameter type T = fa_xa_t
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  T           din_i,
    input  logic       pop_i,
    input  logic       clr_i,
    output logic [1:0] occ_o,
    output T           head_o
);

    T           head_q, head_d;
    T           tail_q, tail_d;
    logic [1:0] occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clr_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = din_i;
                    end else begin
                        tail_d = din_i;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; new entry goes behind the survivor
                    if (occ_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = din_i;
                    end else begin
                        head_d = din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr_i) begin
            assert (!(push_i && !pop_i && occ_q == 2'd2));
            assert (!(pop_i && occ_q == 2'd0));
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/eng_pipe_fa_pcgen.sv
// Fetch PC generator: issues sequential ROM reads under a 2-entry
// credit limit and presents {pc, inst} to xa; commit redirects flush.
module eng_pipe_fa_pcgen
    import eng_pipe_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_rom_en,
    output logic [PC_W-1:0]   o_rom_addr,
    input  logic [INST_W-1:0] i_rom_dout,
    output logic              o_xa_vld,
    output logic [PC_W-1:0]   o_xa_pc_r,
    output logic [INST_W-1:0] o_xa_inst_r,
    input  logic              i_xa_rdy,
    input  logic              i_ca_redirect_vld,
    input  logic [PC_W-1:0]   i_ca_redirect_pc
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    fa_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            infl_q, infl_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;

    logic [1:0] occ;
    ent_t       head;
    ent_t       push_ent;
    logic       vld;
    logic       pop;
    logic       push;
    logic       active;
    logic [2:0] demand;
    logic       rom_en;
    logic [PC_W-1:0] rom_addr;

    assign vld      = (occ != 2'd0);
    assign pop      = vld & i_xa_rdy;
    assign push     = infl_q & ~i_ca_redirect_vld;
    assign push_ent = '{pc: req_pc_q, inst: i_rom_dout};
    // the start cycle already counts as a fetch cycle
    assign active   = (state_q == RUN) | i_start;
    assign demand   = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rom_en   = 1'b0;
        rom_addr = pc_q;
        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (active) begin
            if (i_ca_redirect_vld) begin
                rom_en   = 1'b1;
                rom_addr = i_ca_redirect_pc;
            end else begin
                rom_en = (demand < 3'd2);
            end
        end
        if (rom_en) begin
            pc_d = rom_addr + PC_W'(1);
        end else if (i_ca_redirect_vld) begin
            pc_d = i_ca_redirect_pc;
        end
        infl_d   = rom_en;
        req_pc_d = rom_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            infl_q   <= 1'b0;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            infl_q   <= infl_d;
            req_pc_q <= req_pc_d;
        end
    end

    eng_pipe_fa_q #(
        .T (ent_t)
    ) u_q (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .din_i  (push_ent),
        .pop_i  (pop),
        .clr_i  (i_ca_redirect_vld),
        .occ_o  (occ),
        .head_o (head)
    );

    assign o_busy      = (state_q == RUN);
    assign o_rom_en    = rom_en;
    assign o_rom_addr  = rom_addr;
    assign o_xa_vld    = vld;
    assign o_xa_pc_r   = head.pc;
    assign o_xa_inst_r = head.inst;

endmodule

// File: tb/tb_eng_pipe_fa_pcgen.sv
// Bench for eng_pipe_fa_pcgen: scenario tasks plus a randomized
// stream scored against the expected in-order PC sequence.
module tb_eng_pipe_fa_pcgen;

    logic        clk = 1'b0;
    logic        rst, start, rdy, redir;
    logic [15:0] rpc;

    logic        busy, rom_en, vld;
    logic [15:0] rom_addr, pc;
    logic [31:0] rom_dout, inst;

    logic        busy2, rom_en2, vld2;
    logic [15:0] rom_addr2, pc2;
    logic [31:0] rom_dout2, inst2;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [15:0] a);
        return {a ^ 16'hC35A, ~a + 16'd7};
    endfunction

    always @(posedge clk) if (rom_en) rom_dout <= rom_f(rom_addr);
    always @(posedge clk) if (rom_en2) rom_dout2 <= rom_f(rom_addr2);

    eng_pipe_fa_pcgen dut (
        .clk (clk), .rst (rst), .i_start (start), .o_busy (busy),
        .o_rom_en (rom_en), .o_rom_addr (rom_addr), .i_rom_dout (rom_dout),
        .o_xa_vld (vld), .o_xa_pc_r (pc), .o_xa_inst_r (inst),
        .i_xa_rdy (rdy), .i_ca_redirect_vld (redir),
        .i_ca_redirect_pc (rpc)
    );

    eng_pipe_fa_pcgen #(.RESET_PC(16'hFFFE)) dut2 (
        .clk (clk), .rst (rst), .i_start (start), .o_busy (busy2),
        .o_rom_en (rom_en2), .o_rom_addr (rom_addr2), .i_rom_dout (rom_dout2),
        .o_xa_vld (vld2), .o_xa_pc_r (pc2), .o_xa_inst_r (inst2),
        .i_xa_rdy (rdy), .i_ca_redirect_vld (redir),
        .i_ca_redirect_pc (rpc)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rdy = 1'b0; redir = 1'b0; rpc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, rom_en, vld} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctl: got busy/en/vld=%b want 000", {busy, rom_en, vld});
        end
        n_cmp++;
        if ({pc, inst} !== 48'h0) begin
            n_bad++;
            $display("FAIL reset_head: got %h/%h want 0/0", pc, inst);
        end
        n_cmp++;
        if ({vld2, pc2, busy2} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_dut2: got vld=%b pc=%h want 0/0", vld2, pc2);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_start();
        start = 1'b1; rdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rom_en, rom_addr, vld} !== {1'b1, 16'h0000, 1'b0}) begin
            n_bad++;
            $display("FAIL start_t0: got en=%b addr=%h vld=%b want 1/0000/0", rom_en, rom_addr, vld);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, rom_en, rom_addr, vld} !== {2'b11, 16'h0001, 1'b0}) begin
            n_bad++;
            $display("FAIL start_t1: got busy=%b en=%b addr=%h vld=%b want 1/1/0001/0", busy, rom_en, rom_addr, vld);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({vld, pc, inst, rom_addr} !== {1'b1, 16'h0000, rom_f(16'h0000), 16'h0002}) begin
            n_bad++;
            $display("FAIL start_t2: got vld=%b pc=%h inst=%h addr=%h want 1/0000/%h/0002", vld, pc, inst, rom_addr, rom_f(16'h0));
        end
        exp_pc = 16'h0001;
        @(posedge clk); #1;
    endtask

    task automatic test_stream(input int n);
        rdy = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vld, pc, inst} !== {1'b1, exp_pc, rom_f(exp_pc)}) begin
                n_bad++;
                $display("FAIL stream: got vld=%b pc=%h inst=%h want 1/%h/%h", vld, pc, inst, exp_pc, rom_f(exp_pc));
            end
            exp_pc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vld, pc, inst} !== {1'b1, exp_pc, rom_f(exp_pc)}) begin
                n_bad++;
                $display("FAIL stall_head: got vld=%b pc=%h inst=%h want 1/%h", vld, pc, inst, exp_pc);
            end
            n_cmp++;
            if (rom_en !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_rom_en: got %b want 0", rom_en);
            end
            @(posedge clk); #1;
        end
        test_stream(8);
    endtask

    task automatic test_redirect();
        rdy = 1'b0; redir = 1'b1; rpc = 16'h0040;
        @(negedge clk);
        n_cmp++;
        if ({rom_en, rom_addr} !== {1'b1, 16'h0040}) begin
            n_bad++;
            $display("FAIL redir_issue: got en=%b addr=%h want 1/0040", rom_en, rom_addr);
        end
        @(posedge clk); #1;
        redir = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vld !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_flush: got vld=%b want 0", vld);
        end
        @(posedge clk); #1;
        exp_pc = 16'h0040;
        test_stream(2);
        rdy = 1'b0; redir = 1'b1; rpc = 16'h0100;
        @(posedge clk); #1;
        rpc = 16'h0200;
        @(posedge clk); #1;
        redir = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vld !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_flush: got vld=%b want 0", vld);
        end
        @(posedge clk); #1;
        exp_pc = 16'h0200;
        test_stream(3);
    endtask

    task automatic test_wrap();
        rst = 1'b1; rdy = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rom_en2, rom_addr2} !== {1'b1, 16'hFFFE}) begin
            n_bad++;
            $display("FAIL wrap_issue: got en=%b addr=%h want 1/fffe", rom_en2, rom_addr2);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        exp_pc = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vld2, pc2, inst2} !== {1'b1, exp_pc, rom_f(exp_pc)}) begin
                n_bad++;
                $display("FAIL wrap_seq: got vld=%b pc=%h inst=%h want 1/%h", vld2, pc2, inst2, exp_pc);
            end
            exp_pc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({vld, busy, rom_en, pc} !== 19'h0) begin
            n_bad++;
            $display("FAIL rst_mid: got vld=%b busy=%b en=%b pc=%h want 0/0/0/0000", vld, busy, rom_en, pc);
        end
        @(posedge clk); #1;
        redir = 1'b1; rpc = 16'h0123;
        @(negedge clk);
        n_cmp++;
        if ({rom_en, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_redir: got en=%b busy=%b want 0/0", rom_en, busy);
        end
        @(posedge clk); #1;
        redir = 1'b0; start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({rom_en, rom_addr} !== {1'b1, 16'h0123}) begin
            n_bad++;
            $display("FAIL idle_redir_start: got en=%b addr=%h want 1/0123", rom_en, rom_addr);
        end
        @(posedge clk); #1;
        start = 1'b0; rdy = 1'b1;
        @(posedge clk); #1;
        exp_pc = 16'h0123;
        test_stream(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1; redir = 1'b1; rpc = 16'h0300;
        @(negedge clk);
        n_cmp++;
        if ({rom_en, rom_addr} !== {1'b1, 16'h0300}) begin
            n_bad++;
            $display("FAIL start_redir: got en=%b addr=%h want 1/0300", rom_en, rom_addr);
        end
        @(posedge clk); #1;
        start = 1'b0; redir = 1'b0;
        @(posedge clk); #1;
        exp_pc = 16'h0300;
        test_stream(2);
    endtask

    task automatic test_random(input int n);
        logic        hold = 1'b0;
        logic [15:0] hpc  = '0;
        logic [31:0] hinst = '0;
        for (int i = 0; i < n; i++) begin
            rdy   = ($urandom_range(3) != 0);
            redir = ($urandom_range(15) == 0);
            rpc   = 16'($urandom);
            @(negedge clk);
            if (hold) begin
                n_cmp++;
                if ({vld, pc, inst} !== {1'b1, hpc, hinst}) begin
                    n_bad++;
                    $display("FAIL rnd_stable: got vld=%b pc=%h want 1/%h", vld, pc, hpc);
                end
            end
            if (vld && rdy) begin
                n_cmp++;
                if ({pc, inst} !== {exp_pc, rom_f(exp_pc)}) begin
                    n_bad++;
                    $display("FAIL rnd_xfer: got pc=%h inst=%h want %h/%h", pc, inst, exp_pc, rom_f(exp_pc));
                end
                exp_pc++;
            end
            if (redir) begin
                n_cmp++;
                if ({rom_en, rom_addr} !== {1'b1, rpc}) begin
                    n_bad++;
                    $display("FAIL rnd_redir: got en=%b addr=%h want 1/%h", rom_en, rom_addr, rpc);
                end
                exp_pc = rpc;
            end
            hold  = vld && !rdy && !redir;
            hpc   = pc;
            hinst = inst;
            @(posedge clk); #1;
        end
        redir = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_stream(16);
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
